lcd_cmd_seq: RTL and testbench

Command sequencer directly upstream of the LCD controller.
- Buffers host commands in a FIFO.
- Issues each command to the controller as a single-cycle cmd/cmd_valid pulse, only while the controller's busy output is low.
- Holds off after a WRITE until the controller's done pulse, counts completed frames and discards illegal opcodes.

---
 rtl/lcd_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: command sequencer placed ahead of the LCD controller.
// Host commands are buffered in a FIFO. Each one goes to the controller as a
// single-cycle cmd/cmd_valid pulse, and only while busy is low. After a WRITE
// (opcode 0) the sequencer holds off until the controller's done pulse and
// counts the completed frame. Opcodes above MAX_OP are dropped and reported.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   host_cmd/host_valid   host push interface; host_ready = (count < DEPTH)
//   busy, done            status from the LCD controller
//   cmd, cmd_valid        registered command and its one-cycle issue strobe
//   flush                 synchronous FIFO clear
//   fifo_count            number of entries held
//   frame_cnt             completed WRITE frames, wraps at 255
//   cmd_err               one-cycle pulse when an illegal opcode is dropped
//   seq_idle              FSM in IDLE with an empty FIFO
module lcd_cmd_seq #(
  parameter int DEPTH  = 8,
  parameter int CMD_W  = 4,
  parameter int MAX_OP = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CMD_W-1:0]         host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     busy,
  input  logic                     done,
  output logic [CMD_W-1:0]         cmd,
  output logic                     cmd_valid,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               frame_cnt,
  output logic                     cmd_err,
  output logic                     seq_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [CMD_W-1:0] MAX_OP_C = CMD_W'(MAX_OP);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_err_q, cmd_err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic             head_illegal;

  assign head         = mem_q[rd_ptr_q];
  assign head_illegal = (head > MAX_OP_C);
  // host_ready looks only at the registered count, so a same-cycle pop
  // cannot open a slot for the host.
  assign host_ready   = (count_q < DEPTH_C);
  assign push         = host_valid && host_ready && !flush;

  // Sequencer FSM: next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Holding off while flushing keeps the entry being cleared from
        // being issued in the same cycle.
        if (!flush && (count_q != '0)) begin
          if (head_illegal) begin
            // Drops never talk to the controller, so busy does not gate them.
            pop       = 1'b1;
            cmd_err_d = 1'b1;
          end else if (!busy) begin
            pop         = 1'b1;
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = (cmd_q == '0) ? WAIT_DONE : GAP;
      end
      GAP: begin
        // Dead cycle so the controller's busy for this command is seen in IDLE.
        state_d = IDLE;
      end
      WAIT_DONE: begin
        if (done) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = host_cmd;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      frame_cnt_q <= frame_cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_err    = cmd_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign fifo_count = count_q;
  assign seq_idle   = (state_q == IDLE) && (count_q == '0);

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq. Expected issues and drops are queued
// when a push is accepted and compared, in order, as the DUT produces them.
module tb_lcd_cmd_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       busy;
  logic       done;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       flush;
  logic [3:0] fifo_count;
  logic [7:0] frame_cnt;
  logic       cmd_err;
  logic       seq_idle;

  always #5 clk = ~clk;

  lcd_cmd_seq #(
    .DEPTH (8),
    .CMD_W (4),
    .MAX_OP(11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host_cmd  (host_cmd),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .busy      (busy),
    .done      (done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .flush     (flush),
    .fifo_count(fifo_count),
    .frame_cnt (frame_cnt),
    .cmd_err   (cmd_err),
    .seq_idle  (seq_idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int issue_cnt = 0;
  int err_cnt   = 0;
  int issue_log[$];
  logic [4:0] sb[$];      // {is_drop, opcode}
  logic [4:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset && (cmd_valid || cmd_err)) begin
      chk("exclusive", 32'(cmd_valid & cmd_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'({cmd_err, cmd_valid}), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_kind", 32'(cmd_err), 32'(mon_exp[4]));
        if (cmd_valid) chk("cmd", 32'(cmd), 32'(mon_exp[3:0]));
      end
      if (cmd_valid) begin
        issue_cnt++;
        issue_log.push_back(cyc);
      end
      if (cmd_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v, input bit acc);
    chk("host_ready", 32'(host_ready), 32'(acc));
    host_cmd   = v;
    host_valid = 1'b1;
    if (acc) sb.push_back({(v > 4'd11), v});
    step();
    host_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k = 0;
    while (issue_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("issue_timeout", 32'(issue_cnt >= n), 32'd1);
  endtask

  task automatic wait_errs(input int n, input int budget);
    int k = 0;
    while (err_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk("err_timeout", 32'(err_cnt >= n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int dc;
    reset = 1'b0; host_cmd = '0; host_valid = 1'b0; busy = 1'b1;
    done = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_cmd",        32'(cmd),        32'd0);
    chk("rst_cmd_valid",  32'(cmd_valid),  32'd0);
    chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    chk("rst_cmd_err",    32'(cmd_err),    32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_seq_idle",   32'(seq_idle),   32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    reset = 1'b1;

    // Boot hold: commands queue while busy is high.
    push(4'd1, 1'b1); push(4'd5, 1'b1); push(4'd9, 1'b1);
    repeat (61) step();
    chk("boot_no_issue", 32'(issue_cnt),  32'd0);
    chk("boot_count",    32'(fifo_count), 32'd3);
    chk("boot_not_idle", 32'(seq_idle),   32'd0);
    b = cyc;
    busy = 1'b0;
    wait_issues(3, 30);
    chk("boot_first",   32'(issue_log[0]),                32'(b + 1));
    chk("boot_space01", 32'(issue_log[1] - issue_log[0]), 32'd3);
    chk("boot_space12", 32'(issue_log[2] - issue_log[1]), 32'd3);
    repeat (3) step();
    chk("boot_count_end", 32'(fifo_count), 32'd0);
    chk("boot_idle_end",  32'(seq_idle),   32'd1);

    // WRITE gating: the next command waits for done.
    push(4'd0, 1'b1); push(4'd2, 1'b1);
    wait_issues(4, 10);
    busy = 1'b1;
    repeat (64) step();
    busy = 1'b0;
    repeat (10) step();
    chk("write_gate",      32'(issue_cnt), 32'd4);
    chk("write_frame_pre", 32'(frame_cnt), 32'd0);
    dc = cyc;
    done = 1'b1; step(); done = 1'b0;
    chk("write_frame", 32'(frame_cnt), 32'd1);
    wait_issues(5, 10);
    chk("write_next_issue", 32'(issue_log[issue_log.size() - 1]), 32'(dc + 2));
    repeat (3) step();
    done = 1'b1; step(); done = 1'b0;
    chk("stray_done", 32'(frame_cnt), 32'd1);

    // Full FIFO.
    busy = 1'b1;
    for (int i = 1; i <= 10; i++) push(4'(i), (i <= 8));
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_ready", 32'(host_ready), 32'd0);
    busy = 1'b0;
    wait_issues(13, 60);
    repeat (3) step();
    chk("full_drain", 32'(fifo_count), 32'd0);
    chk("full_idle",  32'(seq_idle),   32'd1);

    // Illegal opcode dropped between two legal ones.
    push(4'd3, 1'b1); push(4'd14, 1'b1); push(4'd4, 1'b1);
    wait_issues(15, 30);
    wait_errs(1, 30);
    repeat (3) step();
    chk("illegal_sb_empty", 32'(sb.size()), 32'd0);
    chk("illegal_errs",     32'(err_cnt),   32'd1);

    // Flush with a concurrent push.
    busy = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i), 1'b1);
    host_cmd = 4'd7; host_valid = 1'b1; flush = 1'b1;
    sb.delete();
    step();
    flush = 1'b0; host_valid = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_ready", 32'(host_ready), 32'd1);
    busy = 1'b0;
    repeat (8) step();
    chk("flush_no_issue", 32'(issue_cnt), 32'd15);
    chk("flush_idle",     32'(seq_idle),  32'd1);

    // Reset in the middle of WAIT_DONE.
    busy = 1'b1;
    push(4'd0, 1'b1); push(4'd6, 1'b1);
    busy = 1'b0;
    wait_issues(16, 10);
    repeat (3) step();
    chk("wd_held", 32'(fifo_count), 32'd1);
    reset = 1'b0;
    #1;
    sb.delete();
    chk("arst_cmd",        32'(cmd),        32'd0);
    chk("arst_cmd_valid",  32'(cmd_valid),  32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_host_ready", 32'(host_ready), 32'd1);
    chk("arst_seq_idle",   32'(seq_idle),   32'd1);
    chk("arst_frame_cnt",  32'(frame_cnt),  32'd0);
    step();
    reset = 1'b1;
    step();
    done = 1'b1; step(); done = 1'b0;
    repeat (5) step();
    chk("late_done_frame", 32'(frame_cnt), 32'd0);
    chk("late_done_issue", 32'(issue_cnt), 32'd16);
    chk("late_done_idle",  32'(seq_idle),  32'd1);

    // frame_cnt wrap over 256 WRITE frames.
    for (int i = 0; i < 256; i++) begin
      push(4'd0, 1'b1);
      wait_issues(17 + i, 10);
      done = 1'b1; step(); done = 1'b0;
      if (i == 254) chk("wrap_255", 32'(frame_cnt), 32'd255);
    end
    chk("wrap_zero",     32'(frame_cnt),  32'd0);
    chk("wrap_count",    32'(fifo_count), 32'd0);
    chk("wrap_idle",     32'(seq_idle),   32'd1);
    chk("wrap_errs",     32'(err_cnt),    32'd1);
    chk("wrap_sb_empty", 32'(sb.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
